wbdbgbus_wb_splitter: RTL and testbench



---
 rtl/wbdbgbus_pkg.sv | 40 ++++
 rtl/wbdbgbus_wb_splitter.sv | 186 ++++++++++++++++++
 tb/tb_wbdbgbus_wb_splitter.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/wbdbgbus_pkg.sv
// Shared wbdbgbus constants and types, including the Wishbone splitter FSM
// state encoding and its address decode helper.
package wbdbgbus_pkg;

  localparam int WB_ADDR_W            = 32;
  localparam int WB_DATA_W            = 32;
  localparam int DEFAULT_TIMEOUT_CLKS = 1024;

  typedef enum logic [1:0] {
    SPL_IDLE,
    SPL_ISSUE,
    SPL_WAIT,
    SPL_UNMAP
  } splitter_state_t;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_S0,
    SEL_S1
  } slave_sel_t;

  // Slave 0 is checked first so that it takes priority when the windows overlap.
  function automatic slave_sel_t decode_slave(
    input logic [WB_ADDR_W-1:0] addr,
    input logic [WB_ADDR_W-1:0] s0_base,
    input logic [WB_ADDR_W-1:0] s0_mask,
    input logic [WB_ADDR_W-1:0] s1_base,
    input logic [WB_ADDR_W-1:0] s1_mask
  );
    slave_sel_t sel;
    sel = SEL_NONE;
    if ((addr & s0_mask) == s0_base) begin
      sel = SEL_S0;
    end else if ((addr & s1_mask) == s1_base) begin
      sel = SEL_S1;
    end
    return sel;
  endfunction

endpackage

// File: rtl/wbdbgbus_wb_splitter.sv
// Routes single Wishbone transactions from the debug-bus master to one of two
// slaves, with unmapped-address errors, a response timeout and master abort.
module wbdbgbus_wb_splitter
  import wbdbgbus_pkg::*;
#(
  parameter logic [WB_ADDR_W-1:0] S0_BASE      = 32'h0000_0000,
  parameter logic [WB_ADDR_W-1:0] S0_MASK      = 32'hFFFF_FF80,
  parameter logic [WB_ADDR_W-1:0] S1_BASE      = 32'h0001_0000,
  parameter logic [WB_ADDR_W-1:0] S1_MASK      = 32'hFFFF_0000,
  parameter int                   TIMEOUT_CLKS = DEFAULT_TIMEOUT_CLKS
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,

  input  logic                 i_wb_cyc,
  input  logic                 i_wb_stb,
  input  logic                 i_wb_we,
  input  logic [WB_ADDR_W-1:0] i_wb_addr,
  input  logic [WB_DATA_W-1:0] i_wb_data,
  output logic                 o_wb_ack,
  output logic                 o_wb_err,
  output logic                 o_wb_stall,
  output logic [WB_DATA_W-1:0] o_wb_data,

  output logic                 o_s0_cyc,
  output logic                 o_s0_stb,
  output logic                 o_s0_we,
  output logic [WB_ADDR_W-1:0] o_s0_addr,
  output logic [WB_DATA_W-1:0] o_s0_data,
  input  logic                 i_s0_ack,
  input  logic                 i_s0_err,
  input  logic                 i_s0_stall,
  input  logic [WB_DATA_W-1:0] i_s0_data,

  output logic                 o_s1_cyc,
  output logic                 o_s1_stb,
  output logic                 o_s1_we,
  output logic [WB_ADDR_W-1:0] o_s1_addr,
  output logic [WB_DATA_W-1:0] o_s1_data,
  input  logic                 i_s1_ack,
  input  logic                 i_s1_err,
  input  logic                 i_s1_stall,
  input  logic [WB_DATA_W-1:0] i_s1_data
);

  localparam int              CNT_W    = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(TIMEOUT_CLKS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CLKS);

  splitter_state_t r_state, w_state_nxt;

  logic                 r_sel_s1;
  logic                 r_we;
  logic [WB_ADDR_W-1:0] r_addr;
  logic [WB_DATA_W-1:0] r_wdata;
  logic [CNT_W-1:0]     r_cnt;

  logic                 r_ack, r_err, r_stall;
  logic [WB_DATA_W-1:0] r_rdata;

  logic                 w_ack_nxt, w_err_nxt, w_latch, w_busy;
  logic [WB_DATA_W-1:0] w_rdata_nxt;
  slave_sel_t           w_dec;

  logic                 w_s_ack, w_s_err, w_s_stall;
  logic [WB_DATA_W-1:0] w_s_data;

  assign w_dec = decode_slave(i_wb_addr, S0_BASE, S0_MASK, S1_BASE, S1_MASK);
  assign w_busy = (r_state == SPL_ISSUE) || (r_state == SPL_WAIT);

  // Only the latched target's response lines are ever looked at.
  assign w_s_ack   = r_sel_s1 ? i_s1_ack   : i_s0_ack;
  assign w_s_err   = r_sel_s1 ? i_s1_err   : i_s0_err;
  assign w_s_stall = r_sel_s1 ? i_s1_stall : i_s0_stall;
  assign w_s_data  = r_sel_s1 ? i_s1_data  : i_s0_data;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= SPL_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Response priority while busy: abort, then err, then ack, then timeout.
  always_comb begin
    w_state_nxt = r_state;
    w_ack_nxt   = 1'b0;
    w_err_nxt   = 1'b0;
    w_rdata_nxt = '0;
    w_latch     = 1'b0;
    case (r_state)
      SPL_IDLE: begin
        if (i_wb_cyc && i_wb_stb) begin
          w_latch = 1'b1;
          if (w_dec == SEL_NONE) begin
            w_state_nxt = SPL_UNMAP;
            w_err_nxt   = 1'b1;
          end else begin
            w_state_nxt = SPL_ISSUE;
          end
        end
      end
      SPL_ISSUE, SPL_WAIT: begin
        if (!i_wb_cyc) begin
          w_state_nxt = SPL_IDLE;
        end else if (w_s_err) begin
          w_state_nxt = SPL_IDLE;
          w_err_nxt   = 1'b1;
        end else if (w_s_ack) begin
          w_state_nxt = SPL_IDLE;
          w_ack_nxt   = 1'b1;
          w_rdata_nxt = w_s_data;
        end else if (r_cnt == CNT_TERM) begin
          w_state_nxt = SPL_IDLE;
          w_err_nxt   = 1'b1;
        end else if ((r_state == SPL_ISSUE) && !w_s_stall) begin
          w_state_nxt = SPL_WAIT;
        end
      end
      SPL_UNMAP: begin
        w_state_nxt = SPL_IDLE;
      end
      default: begin
        w_state_nxt = SPL_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sel_s1 <= 1'b0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
    end else if (w_latch) begin
      r_sel_s1 <= (w_dec == SEL_S1);
      r_we     <= i_wb_we;
      r_addr   <= i_wb_addr;
      r_wdata  <= i_wb_data;
    end
  end

  // Counter is held at zero in IDLE, so it always starts from zero on ISSUE entry.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (r_state == SPL_IDLE) begin
      r_cnt <= '0;
    end else if (w_busy && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_stall <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_ack   <= w_ack_nxt;
      r_err   <= w_err_nxt;
      r_stall <= (w_state_nxt != SPL_IDLE);
      r_rdata <= w_rdata_nxt;
    end
  end

  assign o_wb_ack   = r_ack;
  assign o_wb_err   = r_err;
  assign o_wb_stall = r_stall;
  assign o_wb_data  = r_rdata;

  assign o_s0_cyc  = w_busy && !r_sel_s1;
  assign o_s0_stb  = (r_state == SPL_ISSUE) && !r_sel_s1;
  assign o_s0_we   = r_we;
  assign o_s0_addr = r_addr;
  assign o_s0_data = r_wdata;

  assign o_s1_cyc  = w_busy && r_sel_s1;
  assign o_s1_stb  = (r_state == SPL_ISSUE) && r_sel_s1;
  assign o_s1_we   = r_we;
  assign o_s1_addr = r_addr;
  assign o_s1_data = r_wdata;

endmodule

// File: tb/tb_wbdbgbus_wb_splitter.sv
// Directed bench for wbdbgbus_wb_splitter: a table of single transactions with
// hand-computed timing, plus abort and mid-transaction reset sequences.
module tb_wbdbgbus_wb_splitter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_wb_cyc, i_wb_stb, i_wb_we;
  logic [31:0] i_wb_addr, i_wb_data;
  logic        o_wb_ack, o_wb_err, o_wb_stall;
  logic [31:0] o_wb_data;
  logic        o_s0_cyc, o_s0_stb, o_s0_we;
  logic [31:0] o_s0_addr, o_s0_data;
  logic        i_s0_ack, i_s0_err, i_s0_stall;
  logic [31:0] i_s0_data;
  logic        o_s1_cyc, o_s1_stb, o_s1_we;
  logic [31:0] o_s1_addr, o_s1_data;
  logic        i_s1_ack, i_s1_err, i_s1_stall;
  logic [31:0] i_s1_data;

  int numVectors = 0;
  int numMiscompares = 0;

  always #5 clk = ~clk;

  // Slave 1 window widened to 0x0000_0000..0x0001_FFFF so it overlaps slave 0.
  wbdbgbus_wb_splitter #(
    .S0_BASE(32'h0000_0000), .S0_MASK(32'hFFFF_FF80),
    .S1_BASE(32'h0000_0000), .S1_MASK(32'hFFFE_0000),
    .TIMEOUT_CLKS(16)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_wb_cyc(i_wb_cyc), .i_wb_stb(i_wb_stb), .i_wb_we(i_wb_we),
    .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data),
    .o_wb_ack(o_wb_ack), .o_wb_err(o_wb_err), .o_wb_stall(o_wb_stall), .o_wb_data(o_wb_data),
    .o_s0_cyc(o_s0_cyc), .o_s0_stb(o_s0_stb), .o_s0_we(o_s0_we),
    .o_s0_addr(o_s0_addr), .o_s0_data(o_s0_data),
    .i_s0_ack(i_s0_ack), .i_s0_err(i_s0_err), .i_s0_stall(i_s0_stall), .i_s0_data(i_s0_data),
    .o_s1_cyc(o_s1_cyc), .o_s1_stb(o_s1_stb), .o_s1_we(o_s1_we),
    .o_s1_addr(o_s1_addr), .o_s1_data(o_s1_data),
    .i_s1_ack(i_s1_ack), .i_s1_err(i_s1_err), .i_s1_stall(i_s1_stall), .i_s1_data(i_s1_data)
  );

  typedef struct {
    string       name;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          slave;
    int          stallCycles;
    int          respCycle;
    logic        respAck;
    logic        respErr;
    logic [31:0] rdata;
    int          expStb;
    int          expLatency;
    logic        expAck;
    logic        expErr;
    logic [31:0] expData;
  } vec_t;

  vec_t vecs[$];

  function automatic void addVec(string name, logic we, logic [31:0] addr, logic [31:0] wdata,
                                 int slave, int stallCycles, int respCycle, logic respAck,
                                 logic respErr, logic [31:0] rdata, int expStb, int expLatency,
                                 logic expAck, logic expErr, logic [31:0] expData);
    vec_t v;
    v.name = name; v.we = we; v.addr = addr; v.wdata = wdata; v.slave = slave;
    v.stallCycles = stallCycles; v.respCycle = respCycle; v.respAck = respAck;
    v.respErr = respErr; v.rdata = rdata; v.expStb = expStb; v.expLatency = expLatency;
    v.expAck = expAck; v.expErr = expErr; v.expData = expData;
    vecs.push_back(v);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    numVectors++;
    if (actual !== expected) begin
      numMiscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // The addressed slave gets the scripted response; the other one babbles ack/err/data.
  task automatic driveSlaves(input int sel, input logic stall, input logic ack, input logic err,
                             input logic [31:0] data, input int k);
    logic noiseErr;
    noiseErr = ((k % 2) == 1);
    if (sel == 0) begin
      i_s0_stall = stall; i_s0_ack = ack; i_s0_err = err; i_s0_data = data;
    end else begin
      i_s0_stall = 1'b0; i_s0_ack = 1'b1; i_s0_err = noiseErr; i_s0_data = 32'hFFFF_0000;
    end
    if (sel == 1) begin
      i_s1_stall = stall; i_s1_ack = ack; i_s1_err = err; i_s1_data = data;
    end else begin
      i_s1_stall = 1'b0; i_s1_ack = 1'b1; i_s1_err = noiseErr; i_s1_data = 32'h0000_FFFF;
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    int          respK;
    int          stbCount;
    logic        otherActive, dataLeak, stallGap, cycAtResp, gotAck, gotErr, seenWe;
    logic        postResp, postStall;
    logic [31:0] gotData, seenAddr, seenData, postData;
    respK = -1; stbCount = 0; otherActive = 0; dataLeak = 0; stallGap = 0; cycAtResp = 0;
    gotAck = 0; gotErr = 0; gotData = 0; seenAddr = 0; seenData = 0; seenWe = 0;

    @(posedge clk); #1;
    i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = v.we; i_wb_addr = v.addr; i_wb_data = v.wdata;
    driveSlaves(v.slave, 1'b0, 1'b0, 1'b0, 32'h0, 0);
    @(negedge clk);
    checkOutput({v.name, ".idleStall"}, {31'b0, o_wb_stall}, 32'd0);

    for (int k = 0; k < 40 && respK < 0; k++) begin
      @(posedge clk); #1;
      i_wb_stb = 1'b0;
      driveSlaves(v.slave, (k < v.stallCycles), (k == v.respCycle) && v.respAck,
                  (k == v.respCycle) && v.respErr, (k == v.respCycle) ? v.rdata : 32'h5A5A_0000, k);
      @(negedge clk);
      if (k == 0) begin
        seenAddr = (v.slave == 1) ? o_s1_addr : o_s0_addr;
        seenData = (v.slave == 1) ? o_s1_data : o_s0_data;
        seenWe   = (v.slave == 1) ? o_s1_we   : o_s0_we;
      end
      if ((v.slave == 0 && o_s0_stb) || (v.slave == 1 && o_s1_stb)) stbCount++;
      if ((v.slave != 0 && (o_s0_cyc || o_s0_stb)) || (v.slave != 1 && (o_s1_cyc || o_s1_stb)))
        otherActive = 1'b1;
      if (o_wb_ack || o_wb_err) begin
        respK = k; gotAck = o_wb_ack; gotErr = o_wb_err; gotData = o_wb_data;
        cycAtResp = o_s0_cyc || o_s1_cyc;
      end else begin
        if (o_wb_data != 32'h0) dataLeak = 1'b1;
        if (!o_wb_stall) stallGap = 1'b1;
      end
    end

    @(posedge clk); #1;
    i_wb_cyc = 1'b0;
    driveSlaves(v.slave, 1'b0, 1'b0, 1'b0, 32'h0, 0);
    @(negedge clk);
    postResp = o_wb_ack || o_wb_err; postStall = o_wb_stall; postData = o_wb_data;

    checkOutput({v.name, ".latency"}, respK, v.expLatency);
    checkOutput({v.name, ".ack"}, {31'b0, gotAck}, {31'b0, v.expAck});
    checkOutput({v.name, ".err"}, {31'b0, gotErr}, {31'b0, v.expErr});
    checkOutput({v.name, ".data"}, gotData, v.expData);
    checkOutput({v.name, ".stbCycles"}, stbCount, v.expStb);
    checkOutput({v.name, ".otherSlaveIdle"}, {31'b0, otherActive}, 32'd0);
    checkOutput({v.name, ".dataZeroNoAck"}, {31'b0, dataLeak}, 32'd0);
    checkOutput({v.name, ".stallWhileBusy"}, {31'b0, stallGap}, 32'd0);
    checkOutput({v.name, ".cycDroppedAtResp"}, {31'b0, cycAtResp}, 32'd0);
    checkOutput({v.name, ".respOneCycle"}, {31'b0, postResp}, 32'd0);
    checkOutput({v.name, ".postStall"}, {31'b0, postStall}, 32'd0);
    checkOutput({v.name, ".postData"}, postData, 32'd0);
    if (v.slave >= 0) begin
      checkOutput({v.name, ".slaveAddr"}, seenAddr, v.addr);
      checkOutput({v.name, ".slaveData"}, seenData, v.wdata);
      checkOutput({v.name, ".slaveWe"}, {31'b0, seenWe}, {31'b0, v.we});
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic lateResp, sawStall;

    //      name          we    addr          wdata         sl stl rsp ack err rdata         stb lat ack err expData
    addVec("wrS0",        1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 0, 0,  2, 1, 0, 32'h0000_0000, 1,  3, 1, 0, 32'h0000_0000);
    addVec("rdS1Stall",   1'b0, 32'h0001_0004, 32'h0,         1, 3,  4, 1, 0, 32'h1234_5678, 4,  5, 1, 0, 32'h1234_5678);
    addVec("rdS1AckAcc",  1'b0, 32'h0001_0008, 32'h0,         1, 3,  3, 1, 0, 32'hA5A5_5A5A, 4,  4, 1, 0, 32'hA5A5_5A5A);
    addVec("rdUnmapHi",   1'b0, 32'h8000_0000, 32'h0,        -1, 0, -1, 0, 0, 32'h0,         0,  0, 0, 1, 32'h0000_0000);
    addVec("rdS0Top",     1'b0, 32'h0000_007F, 32'h0,         0, 0,  0, 1, 0, 32'hCAFE_F00D, 1,  1, 1, 0, 32'hCAFE_F00D);
    addVec("rdS1Low",     1'b0, 32'h0000_0080, 32'h0,         1, 1,  2, 1, 0, 32'h0BAD_C0DE, 2,  3, 1, 0, 32'h0BAD_C0DE);
    addVec("rdS1Err",     1'b0, 32'h0001_FFFC, 32'h0,         1, 0,  1, 0, 1, 32'h7777_7777, 1,  2, 0, 1, 32'h0000_0000);
    addVec("rdUnmapEdge", 1'b0, 32'h0002_0000, 32'h0,        -1, 0, -1, 0, 0, 32'h0,         0,  0, 0, 1, 32'h0000_0000);
    addVec("wrS0AckErr",  1'b1, 32'h0000_0000, 32'h0102_0304, 0, 0,  1, 1, 1, 32'h9999_9999, 1,  2, 0, 1, 32'h0000_0000);
    addVec("rdTimeout",   1'b0, 32'h0000_0020, 32'h0,         0, 0, -1, 0, 0, 32'h0,         1, 16, 0, 1, 32'h0000_0000);
    addVec("rdAckAtTerm", 1'b0, 32'h0000_0024, 32'h0,         0, 0, 15, 1, 0, 32'h600D_600D, 1, 16, 1, 0, 32'h600D_600D);
    addVec("wrS1Stall2",  1'b1, 32'h0000_1000, 32'h0BB0_0CC0, 1, 2,  5, 1, 0, 32'h0000_0000, 3,  6, 1, 0, 32'h0000_0000);

    rst_n = 1'b0;
    i_wb_cyc = 0; i_wb_stb = 0; i_wb_we = 0; i_wb_addr = 0; i_wb_data = 0;
    driveSlaves(-1, 1'b0, 1'b0, 1'b0, 32'h0, 0);
    #2;
    checkOutput("reset.stall", {31'b0, o_wb_stall}, 32'd0);
    checkOutput("reset.ackErr", {30'b0, o_wb_ack, o_wb_err}, 32'd0);
    checkOutput("reset.data", o_wb_data, 32'd0);
    checkOutput("reset.slaveCycStb", {28'b0, o_s0_cyc, o_s0_stb, o_s1_cyc, o_s1_stb}, 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i]);

    // Master drops cyc while s0 is in WAIT; the later s0 ack must go nowhere.
    @(posedge clk); #1;
    i_wb_cyc = 1; i_wb_stb = 1; i_wb_we = 0; i_wb_addr = 32'h0000_0030;
    driveSlaves(0, 1'b0, 1'b0, 1'b0, 32'h0, 0);
    @(posedge clk); #1;
    i_wb_stb = 0;
    @(negedge clk);
    checkOutput("abort.s0StbIssue", {31'b0, o_s0_stb}, 32'd1);
    @(posedge clk); #1;
    i_wb_cyc = 0;
    @(negedge clk);
    checkOutput("abort.s0CycWait", {31'b0, o_s0_cyc}, 32'd1);
    checkOutput("abort.s0StbWait", {31'b0, o_s0_stb}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("abort.s0CycDropped", {31'b0, o_s0_cyc}, 32'd0);
    checkOutput("abort.stallDropped", {31'b0, o_wb_stall}, 32'd0);
    lateResp = 0;
    for (int k = 3; k < 7; k++) begin
      @(posedge clk); #1;
      driveSlaves(0, 1'b0, (k == 3), 1'b0, 32'hDEAD_0001, k);
      @(negedge clk);
      lateResp = lateResp | o_wb_ack | o_wb_err;
    end
    checkOutput("abort.noLateResp", {31'b0, lateResp}, 32'd0);
    applyStimulus(vecs[0]);

    // Reset pulse while s1 is in WAIT.
    @(posedge clk); #1;
    i_wb_cyc = 1; i_wb_stb = 1; i_wb_we = 1; i_wb_addr = 32'h0001_0004; i_wb_data = 32'h1111_2222;
    driveSlaves(1, 1'b0, 1'b0, 1'b0, 32'h0, 0);
    @(posedge clk); #1;
    i_wb_stb = 0;
    @(posedge clk); #1;
    checkOutput("rst.preS1Cyc", {31'b0, o_s1_cyc}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst.s1CycStb", {30'b0, o_s1_cyc, o_s1_stb}, 32'd0);
    checkOutput("rst.stall", {31'b0, o_wb_stall}, 32'd0);
    checkOutput("rst.ackErr", {30'b0, o_wb_ack, o_wb_err}, 32'd0);
    checkOutput("rst.wbData", o_wb_data, 32'd0);
    checkOutput("rst.s1Addr", o_s1_addr, 32'd0);
    checkOutput("rst.s1Data", o_s1_data, 32'd0);
    i_wb_cyc = 0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    lateResp = 0; sawStall = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      driveSlaves(1, 1'b0, 1'b1, 1'b0, 32'hBEEF_0002, k);
      @(negedge clk);
      lateResp = lateResp | o_wb_ack | o_wb_err;
      sawStall = sawStall | o_wb_stall;
    end
    checkOutput("rst.noRespAfter", {31'b0, lateResp}, 32'd0);
    checkOutput("rst.idleAfter", {31'b0, sawStall}, 32'd0);
    applyStimulus(vecs[1]);

    $display("== %0d vectors applied, %0d miscompares ==", numVectors, numMiscompares);
    $finish;
  end

endmodule
